// File: rtl/life_pkg.sv
// Shared definitions for the life-logic datapath: scheduler state encoding,
// the default speed-input width (also used by the logic engine) and the
// generation-period helper.
package life_pkg;

    // Default width of the speed input; max period is 2**LIFE_LOG_MAX_SPEED frames.
    localparam int LIFE_LOG_MAX_SPEED = 3;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        SWAP_WAIT = 2'd2
    } sched_state_t;

    // Frames per generation: 2**log_max - speed. Speed 0 is the slowest setting,
    // and because speed < 2**log_max the result is never zero.
    function automatic int unsigned frames_per_gen(
        input int unsigned speed,
        input int unsigned log_max = LIFE_LOG_MAX_SPEED
    );
        return (32'd1 << log_max) - speed;
    endfunction

endpackage

// File: rtl/gen_rate_div.sv
// Frame-rate divider: counts enabled vsync pulses and flags launch eligibility.
// Latency: eligible_o is combinational from vsync_i; counter updates next edge.
// Backpressure: none; enable_i low freezes the count, clear_i has priority.
//
// Ports:
//   clk_i, rst_n_i  clock and async active-low reset
//   vsync_i         one-cycle frame pulse
//   enable_i        count vsync only when high
//   clear_i         zero the frame counter (launch)
//   speed_i         speed setting, 0 = slowest
//   eligible_o      this vsync reaches or passes the generation period
module gen_rate_div
    import life_pkg::*;
#(
    parameter int LOG_MAX_SPEED = LIFE_LOG_MAX_SPEED
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     vsync_i,
    input  logic                     enable_i,
    input  logic                     clear_i,
    input  logic [LOG_MAX_SPEED-1:0] speed_i,
    output logic                     eligible_o
);

    logic [LOG_MAX_SPEED:0] cnt_q;
    logic [LOG_MAX_SPEED:0] cnt_d;
    logic [LOG_MAX_SPEED:0] cnt_inc;
    logic [31:0]            period;
    logic [31:0]            cnt_inc_ext;

    assign cnt_inc     = cnt_q + {{LOG_MAX_SPEED{1'b0}}, 1'b1};
    assign period      = frames_per_gen(32'(speed_i), LOG_MAX_SPEED);
    assign cnt_inc_ext = 32'(cnt_inc);

    // >= rather than == so that raising the speed mid-count launches at once
    // instead of running the counter round a wrap.
    assign eligible_o = vsync_i & enable_i & (cnt_inc_ext >= period);

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (vsync_i && enable_i) begin
            cnt_d = cnt_inc;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/life_gen_scheduler.sv
// Generation scheduler: divides frames to the generation rate, launches the
// engine, waits for completion and swaps the ping-pong buffer on a frame edge.
// Latency: start_out one cycle after launching vsync; swap one cycle after vsync.
// Backpressure: done_in gates the swap; pause_in holds new launches in IDLE.
//
// Ports:
//   clk_in, rst_n_in  clock and async active-low reset
//   speed_in          generation speed, 0 = slowest (2**LOG_MAX_SPEED frames)
//   vsync_in          one-cycle frame pulse
//   pause_in          level, holds generation advance
//   done_in           one-cycle engine completion pulse
//   step_in           (only with LIFE_STEP_EN) single-step launch while paused
//   start_out         one-cycle pass launch
//   buf_sel_out       displayed/read buffer; engine writes the other one
//   busy_out          pass outstanding or swap pending
//   gen_count_out     completed generations, wraps
//
// Optional feature macro: LIFE_STEP_EN adds step_in.
module life_gen_scheduler
    import life_pkg::*;
#(
    parameter int LOG_MAX_SPEED = LIFE_LOG_MAX_SPEED,
    parameter int GEN_CNT_WIDTH = 16
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic [LOG_MAX_SPEED-1:0] speed_in,
    input  logic                     vsync_in,
    input  logic                     pause_in,
    input  logic                     done_in,
`ifdef LIFE_STEP_EN
    input  logic                     step_in,
`endif
    output logic                     start_out,
    output logic                     buf_sel_out,
    output logic                     busy_out,
    output logic [GEN_CNT_WIDTH-1:0] gen_count_out
);

    sched_state_t             state_q;
    sched_state_t             state_d;
    logic                     start_q;
    logic                     start_d;
    logic                     buf_sel_q;
    logic                     buf_sel_d;
    logic [GEN_CNT_WIDTH-1:0] gen_cnt_q;
    logic [GEN_CNT_WIDTH-1:0] gen_cnt_d;

    logic rate_enable;
    logic eligible;
    logic step_launch;
    logic launch;

    // Frames only count while idle and unpaused; a vsync that coincides with
    // pause rising is therefore neither counted nor launching.
    assign rate_enable = (state_q == IDLE) && !pause_in;

`ifdef LIFE_STEP_EN
    assign step_launch = (state_q == IDLE) && pause_in && step_in;
`else
    assign step_launch = 1'b0;
`endif

    assign launch = eligible | step_launch;

    gen_rate_div #(
        .LOG_MAX_SPEED (LOG_MAX_SPEED)
    ) u_rate_div (
        .clk_i      (clk_in),
        .rst_n_i    (rst_n_in),
        .vsync_i    (vsync_in),
        .enable_i   (rate_enable),
        .clear_i    (launch),
        .speed_i    (speed_in),
        .eligible_o (eligible)
    );

    // State and output registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= IDLE;
            start_q   <= 1'b0;
            buf_sel_q <= 1'b0;
            gen_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            start_q   <= start_d;
            buf_sel_q <= buf_sel_d;
            gen_cnt_q <= gen_cnt_d;
        end
    end

    // Next-state logic. In RUN a coincident vsync is ignored, so done together
    // with vsync still waits for the following frame before swapping.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (launch)   state_d = RUN;
            RUN:       if (done_in)  state_d = SWAP_WAIT;
            SWAP_WAIT: if (vsync_in) state_d = IDLE;
            default:                 state_d = IDLE;
        endcase
    end

    // Output next-values.
    always_comb begin
        start_d   = 1'b0;
        buf_sel_d = buf_sel_q;
        gen_cnt_d = gen_cnt_q;
        case (state_q)
            IDLE: start_d = launch;
            SWAP_WAIT: begin
                if (vsync_in) begin
                    buf_sel_d = ~buf_sel_q;
                    gen_cnt_d = gen_cnt_q + GEN_CNT_WIDTH'(1);
                end
            end
            default: ;
        endcase
    end

    assign start_out     = start_q;
    assign buf_sel_out   = buf_sel_q;
    assign busy_out      = (state_q != IDLE);
    assign gen_count_out = gen_cnt_q;

endmodule

// File: tb/tb_life_gen_scheduler.sv
module tb_life_gen_scheduler;

    localparam int LMS = 3;
    localparam int GCW = 16;

    logic           clk_in = 1'b0;
    logic           rst_n_in;
    logic [LMS-1:0] speed_in;
    logic           vsync_in;
    logic           pause_in;
    logic           done_in;
`ifdef LIFE_STEP_EN
    logic           step_in;
`endif
    logic           start_out;
    logic           buf_sel_out;
    logic           busy_out;
    logic [GCW-1:0] gen_count_out;

    int checks   = 0;
    int failures = 0;
    int starts;

    always #5 clk_in = ~clk_in;

    life_gen_scheduler #(
        .LOG_MAX_SPEED (LMS),
        .GEN_CNT_WIDTH (GCW)
    ) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .speed_in      (speed_in),
        .vsync_in      (vsync_in),
        .pause_in      (pause_in),
        .done_in       (done_in),
`ifdef LIFE_STEP_EN
        .step_in       (step_in),
`endif
        .start_out     (start_out),
        .buf_sel_out   (buf_sel_out),
        .busy_out      (busy_out),
        .gen_count_out (gen_count_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_vsync();
        vsync_in = 1'b1;
        tick();
        vsync_in = 1'b0;
    endtask

    task automatic pulse_done();
        done_in = 1'b1;
        tick();
        done_in = 1'b0;
    endtask

    // One display frame: vsync then a few quiet cycles. Counts start pulses
    // and optionally answers each with an immediate done.
    task automatic frame(input bit auto_done);
        pulse_vsync();
        if (start_out === 1'b1) begin
            starts++;
            if (auto_done) pulse_done();
        end
        idle(2);
    endtask

    initial begin
        rst_n_in = 1'b0;
        speed_in = '0;
        vsync_in = 1'b0;
        pause_in = 1'b0;
        done_in  = 1'b0;
`ifdef LIFE_STEP_EN
        step_in  = 1'b0;
`endif
        idle(3);
        chk("rst_start", start_out, 0);
        chk("rst_buf", buf_sel_out, 0);
        chk("rst_busy", busy_out, 0);
        chk("rst_gen", gen_count_out, 0);
        rst_n_in = 1'b1;
        idle(2);

        // Period 1: first vsync launches.
        speed_in = 3'd7;
        pulse_vsync();
        chk("p1_start", start_out, 1);
        chk("p1_busy_rise", busy_out, 1);
        tick();
        chk("p1_start_one_cycle", start_out, 0);
        pulse_done();
        chk("p1_wait_busy", busy_out, 1);
        chk("p1_wait_buf", buf_sel_out, 0);
        pulse_vsync();
        chk("p1_swap_buf", buf_sel_out, 1);
        chk("p1_swap_gen", gen_count_out, 1);
        chk("p1_busy_fall", busy_out, 0);

        // Period 8: seven counted vsyncs do nothing, the eighth launches.
        speed_in = 3'd0;
        starts = 0;
        for (int i = 0; i < 7; i++) frame(1'b0);
        chk("p8_no_early_start", starts, 0);
        pulse_vsync();
        chk("p8_start_8th", start_out, 1);
        pulse_done();
        pulse_vsync();
        chk("p8_gen", gen_count_out, 2);
        chk("p8_buf", buf_sel_out, 0);

        // 36 frames with immediate done: launch every 9th frame (8 + swap).
        starts = 0;
        for (int i = 0; i < 36; i++) frame(1'b1);
        chk("p8_36_starts", starts, 4);
        chk("p8_36_gen", gen_count_out, 6);
        chk("p8_36_buf", buf_sel_out, 0);
        chk("p8_36_busy", busy_out, 0);

        // Pause raised during RUN: the pass still completes and swaps.
        speed_in = 3'd7;
        pulse_vsync();
        chk("pz_start", start_out, 1);
        pause_in = 1'b1;
        pulse_done();
        pulse_vsync();
        chk("pz_gen", gen_count_out, 7);
        chk("pz_buf", buf_sel_out, 1);
        chk("pz_busy", busy_out, 0);
        starts = 0;
        for (int i = 0; i < 20; i++) frame(1'b1);
        chk("pz_no_start_20", starts, 0);
        chk("pz_gen_held", gen_count_out, 7);
        // Resume at period 3: counting restarts from 0.
        pause_in = 1'b0;
        speed_in = 3'd5;
        starts = 0;
        for (int i = 0; i < 2; i++) frame(1'b0);
        chk("pz_resume_none", starts, 0);
        pulse_vsync();
        chk("pz_resume_start", start_out, 1);
        pulse_done();
        pulse_vsync();
        chk("pz_resume_gen", gen_count_out, 8);

        // done and vsync together in RUN: swap waits for the next vsync.
        speed_in = 3'd7;
        pulse_vsync();
        chk("sim_start", start_out, 1);
        done_in  = 1'b1;
        vsync_in = 1'b1;
        tick();
        done_in  = 1'b0;
        vsync_in = 1'b0;
        chk("sim_no_swap_gen", gen_count_out, 8);
        chk("sim_no_swap_busy", busy_out, 1);
        idle(3);
        pulse_vsync();
        chk("sim_swap_gen", gen_count_out, 9);
        chk("sim_swap_buf", buf_sel_out, 1);
        // done while idle is ignored.
        pulse_done();
        chk("idle_done_busy", busy_out, 0);

        // Pause rising on the launching vsync wins.
        speed_in = 3'd6;
        frame(1'b0);
        pause_in = 1'b1;
        pulse_vsync();
        chk("pw_no_start", start_out, 0);
        chk("pw_no_busy", busy_out, 0);
        pause_in = 1'b0;
        tick();
        pulse_vsync();
        chk("pw_start_after", start_out, 1);
        pulse_done();
        pulse_vsync();
        chk("pw_gen", gen_count_out, 10);

        // Asynchronous reset in the middle of RUN.
        speed_in = 3'd7;
        pulse_vsync();
        tick();
        chk("ar_busy_before", busy_out, 1);
        #3;
        rst_n_in = 1'b0;
        #1;
        chk("ar_busy", busy_out, 0);
        chk("ar_gen", gen_count_out, 0);
        chk("ar_buf", buf_sel_out, 0);
        chk("ar_start", start_out, 0);
        tick();
        rst_n_in = 1'b1;
        tick();
        pulse_done();
        chk("ar_stray_done", busy_out, 0);
        pulse_vsync();
        chk("ar_relaunch", start_out, 1);
        pulse_done();
        pulse_vsync();
        chk("ar_gen_after", gen_count_out, 1);
        chk("ar_buf_after", buf_sel_out, 1);

`ifdef LIFE_STEP_EN
        // Single step while paused launches exactly one pass.
        pause_in = 1'b1;
        step_in  = 1'b1;
        tick();
        step_in  = 1'b0;
        chk("st_start", start_out, 1);
        tick();
        chk("st_one_pulse", start_out, 0);
        pulse_done();
        pulse_vsync();
        chk("st_gen", gen_count_out, 2);
        starts = 0;
        for (int i = 0; i < 3; i++) frame(1'b1);
        chk("st_paused_none", starts, 0);
        // Step while unpaused is ignored.
        pause_in = 1'b0;
        speed_in = 3'd0;
        step_in  = 1'b1;
        tick();
        step_in  = 1'b0;
        chk("st_unpaused_start", start_out, 0);
        chk("st_unpaused_busy", busy_out, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
